// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO phase accumulator.
// The SWEEP state exists only when NCO_SWEEP_EN is defined.
package nco_pkg;

    localparam int NUM_BITS_DEF = 16;
    localparam int ACC_BITS_DEF = 32;

`ifdef NCO_SWEEP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } nco_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } nco_state_t;
`endif

endpackage

// File: rtl/nco_sweep_ctrl.sv
// Linear FTW sweep datapath: adds one step to the current FTW and clamps to the
// stop value on reaching it, overflowing, or when the step is zero.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int ACC_BITS = ACC_BITS_DEF
) (
    input  logic [ACC_BITS-1:0] ftw_cur,
    input  logic [ACC_BITS-1:0] sweep_step,
    input  logic [ACC_BITS-1:0] sweep_stop,
    output logic [ACC_BITS-1:0] ftw_next,
    output logic                sweep_done
);

    logic [ACC_BITS-1:0] step_sum;
    logic                step_carry;

    assign {step_carry, step_sum} = {1'b0, ftw_cur} + {1'b0, sweep_step};

    // A zero step would never reach the stop value, so it finishes at once.
    assign sweep_done = step_carry || (step_sum >= sweep_stop) || (sweep_step == '0);
    assign ftw_next   = sweep_done ? sweep_stop : step_sum;

endmodule

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator with registered, offset phase output and wrap pulse.
// Define NCO_SWEEP_EN to build the linear FTW sweep (SWEEP state, nco_sweep_ctrl).
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int ACC_BITS = ACC_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ACC_BITS-1:0] ftw_in,
    input  logic                ftw_valid,
    output logic                ftw_ready,
    input  logic [NUM_BITS-1:0] phase_off,
    input  logic                phase_clr,
    input  logic                sweep_start,
    input  logic [ACC_BITS-1:0] sweep_step,
    input  logic [ACC_BITS-1:0] sweep_stop,
    output logic                sweep_busy,
    output logic [NUM_BITS-1:0] phase_out,
    output logic                phase_valid,
    output logic                wrap
);

    nco_state_t          state;
    nco_state_t          state_next;
    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] acc_sum;
    logic                acc_carry;
    logic [ACC_BITS-1:0] ftw_active;
    logic [ACC_BITS-1:0] ftw_d;
    logic                ftw_load;
    logic                accumulating;

    assign ftw_load     = ftw_valid && ftw_ready;
    assign accumulating = (state != IDLE);
    assign {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, ftw_active};

`ifdef NCO_SWEEP_EN
    logic [ACC_BITS-1:0] sweep_ftw;
    logic                sweep_done;

    nco_sweep_ctrl #(
        .ACC_BITS(ACC_BITS)
    ) u_sweep_ctrl (
        .ftw_cur   (ftw_active),
        .sweep_step(sweep_step),
        .sweep_stop(sweep_stop),
        .ftw_next  (sweep_ftw),
        .sweep_done(sweep_done)
    );

    assign ftw_ready  = (state != SWEEP);
    assign sweep_busy = (state == SWEEP);
`else
    logic unused_sweep;

    assign unused_sweep = ^{sweep_start, sweep_step, sweep_stop};
    assign ftw_ready    = 1'b1;
    assign sweep_busy   = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ftw_d      = ftw_load ? ftw_in : ftw_active;
        case (state)
            IDLE: begin
                if (ftw_load) state_next = RUN;
            end
            RUN: begin
`ifdef NCO_SWEEP_EN
                if (sweep_start) state_next = SWEEP;
`endif
            end
`ifdef NCO_SWEEP_EN
            SWEEP: begin
                ftw_d = sweep_ftw;
                if (sweep_done) state_next = RUN;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // A clear wins over accumulation and also swallows that cycle's carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            ftw_active  <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state       <= state_next;
            ftw_active  <= ftw_d;
            phase_out   <= acc[ACC_BITS-1 -: NUM_BITS] + phase_off;
            phase_valid <= phase_valid | accumulating;
            if (phase_clr) begin
                acc  <= '0;
                wrap <= 1'b0;
            end else if (accumulating) begin
                acc  <= acc_sum;
                wrap <= acc_carry;
            end else begin
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed self-checking bench for nco_phase_acc (ACC_BITS=32, NUM_BITS=16).
// Covers the sweep when built with NCO_SWEEP_EN, otherwise checks it is inert.
module tb_nco_phase_acc;

    localparam int NUM_BITS = 16;
    localparam int ACC_BITS = 32;

    logic                clk;
    logic                rst;
    logic [ACC_BITS-1:0] ftw_in;
    logic                ftw_valid;
    logic                ftw_ready;
    logic [NUM_BITS-1:0] phase_off;
    logic                phase_clr;
    logic                sweep_start;
    logic [ACC_BITS-1:0] sweep_step;
    logic [ACC_BITS-1:0] sweep_stop;
    logic                sweep_busy;
    logic [NUM_BITS-1:0] phase_out;
    logic                phase_valid;
    logic                wrap;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_phase [8] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                                   16'h0000, 16'h4000, 16'h8000, 16'hC000};
    logic        exp_wrap  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] exp_off   [4] = '{16'h8000, 16'hC000, 16'h0000, 16'h4000};
    logic        exp_owrap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_sweep [4] = '{32'h200, 32'h300, 32'h400, 32'h450};
    logic        exp_busy  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    nco_phase_acc #(
        .NUM_BITS(NUM_BITS),
        .ACC_BITS(ACC_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ftw_in     (ftw_in),
        .ftw_valid  (ftw_valid),
        .ftw_ready  (ftw_ready),
        .phase_off  (phase_off),
        .phase_clr  (phase_clr),
        .sweep_start(sweep_start),
        .sweep_step (sweep_step),
        .sweep_stop (sweep_stop),
        .sweep_busy (sweep_busy),
        .phase_out  (phase_out),
        .phase_valid(phase_valid),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] ftw,
                                  input logic clr, input logic start);
        ftw_valid   = valid;
        ftw_in      = ftw;
        phase_clr   = clr;
        sweep_start = start;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_ports(input string tag, input logic [15:0] po, input logic pv,
                               input logic wr, input logic bz, input logic rd);
        check_output({tag, "_phase_out"},   64'(phase_out),   64'(po));
        check_output({tag, "_phase_valid"}, 64'(phase_valid), 64'(pv));
        check_output({tag, "_wrap"},        64'(wrap),        64'(wr));
        check_output({tag, "_sweep_busy"},  64'(sweep_busy),  64'(bz));
        check_output({tag, "_ftw_ready"},   64'(ftw_ready),   64'(rd));
    endtask

    initial begin
        rst        = 1'b1;
        phase_off  = '0;
        sweep_step = '0;
        sweep_stop = '0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        step(2);
        check_ports("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        step(2);
        check_output("idle_no_valid", 64'(phase_valid), 64'd0);

        // Basic accumulation with a quarter-turn FTW
        apply_stimulus(1'b1, 32'h4000_0000, 1'b0, 1'b0);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("accept_edge_valid", 64'(phase_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_output($sformatf("seq_phase_%0d", i), 64'(phase_out), 64'(exp_phase[i]));
            check_output($sformatf("seq_wrap_%0d", i), 64'(wrap), 64'(exp_wrap[i]));
            check_output($sformatf("seq_valid_%0d", i), 64'(phase_valid), 64'd1);
        end

        phase_off = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_output($sformatf("off_phase_%0d", i), 64'(phase_out), 64'(exp_off[i]));
            check_output($sformatf("off_wrap_%0d", i), 64'(wrap), 64'(exp_owrap[i]));
        end
        phase_off = 16'h0000;

        // Clear on the edge that would carry
        step(3);
        check_output("pre_clr_wrap", 64'(wrap), 64'd0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("clr_wrap", 64'(wrap), 64'd0);
        check_output("clr_phase_prev", 64'(phase_out), 64'h0000_C000);
        step(1);
        check_output("clr_phase_zero", 64'(phase_out), 64'h0000_0000);
        step(1);
        check_output("clr_phase_next", 64'(phase_out), 64'h0000_4000);
        check_output("clr_wrap_next", 64'(wrap), 64'd0);

        // FTW reload while running: old FTW still used on the load edge
        apply_stimulus(1'b1, 32'h1000_0000, 1'b0, 1'b0);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("reload_phase_0", 64'(phase_out), 64'h0000_8000);
        step(1);
        check_output("reload_phase_1", 64'(phase_out), 64'h0000_C000);
        step(1);
        check_output("reload_phase_2", 64'(phase_out), 64'h0000_D000);
        step(1);
        check_output("reload_phase_3", 64'(phase_out), 64'h0000_E000);

`ifdef NCO_SWEEP_EN
        apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        sweep_step = 32'h100;
        sweep_stop = 32'h450;
        check_output("sweep_ftw_loaded", 64'(dut.ftw_active), 64'h100);
        step(1);
        apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_output("sweep_enter_busy", 64'(sweep_busy), 64'd1);
        check_output("sweep_enter_ready", 64'(ftw_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_output($sformatf("sweep_ftw_%0d", i), 64'(dut.ftw_active), 64'(exp_sweep[i]));
            check_output($sformatf("sweep_busy_%0d", i), 64'(sweep_busy), 64'(exp_busy[i]));
            check_output($sformatf("sweep_ready_%0d", i), 64'(ftw_ready), 64'(!exp_busy[i]));
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

        // Start already at the stop value: one SWEEP cycle then back to RUN
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("atstop_busy", 64'(sweep_busy), 64'd1);
        step(1);
        check_output("atstop_done", 64'(sweep_busy), 64'd0);
        check_output("atstop_ftw", 64'(dut.ftw_active), 64'h450);

        sweep_step = 32'h0;
        sweep_stop = 32'h800;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("zerostep_busy", 64'(sweep_busy), 64'd1);
        step(1);
        check_output("zerostep_done", 64'(sweep_busy), 64'd0);
        check_output("zerostep_ftw", 64'(dut.ftw_active), 64'h800);

        // Long sweep, interrupted by reset below
        sweep_step = 32'h100;
        sweep_stop = 32'h1000_0000;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        step(2);
        check_output("midsweep_busy", 64'(sweep_busy), 64'd1);
`else
        sweep_step = 32'h100;
        sweep_stop = 32'h450;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("nosweep_busy", 64'(sweep_busy), 64'd0);
        check_output("nosweep_ready", 64'(ftw_ready), 64'd1);
        check_output("nosweep_ftw", 64'(dut.ftw_active), 64'h1000_0000);
        step(3);
        check_output("nosweep_busy_later", 64'(sweep_busy), 64'd0);
        check_output("nosweep_ftw_later", 64'(dut.ftw_active), 64'h1000_0000);
`endif

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check_ports("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("async_rst_ftw", 64'(dut.ftw_active), 64'h0);
        step(2);
        rst = 1'b0;
        step(3);
        check_output("post_rst_valid", 64'(phase_valid), 64'd0);
        check_output("post_rst_phase", 64'(phase_out), 64'h0);
        apply_stimulus(1'b1, 32'h4000_0000, 1'b0, 1'b0);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_output("relaunch_valid_0", 64'(phase_valid), 64'd0);
        step(1);
        check_output("relaunch_valid_1", 64'(phase_valid), 64'd1);
        check_output("relaunch_phase_1", 64'(phase_out), 64'h0000);
        step(1);
        check_output("relaunch_phase_2", 64'(phase_out), 64'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
